// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 640x480@60 timing constants, derived window bounds and monitor state enum
package vga_timing_pkg;
  localparam int H_ACTIVE = 640;
  localparam int H_FP = 16;
  localparam int H_SYNC = 96;
  localparam int H_BP = 48;
  localparam int V_ACTIVE = 480;
  localparam int V_FP = 10;
  localparam int V_SYNC = 2;
  localparam int V_BP = 33;
  localparam int LOCK_FRAMES = 2;
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int H_ACT_START = H_SYNC + H_BP;
  localparam int V_ACT_START = V_SYNC + V_BP;
  typedef enum logic [1:0] {SEARCH, ALIGN, LOCKED} state_t;
endpackage

// File: rtl/sync_edge_detect.sv
// sync_edge_detect: registers one sync input (reset high) and flags fall/rise (in: clk rst sig; out: fall rise)
module sync_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic fall,
  output logic rise
);
  logic q;
  always_ff @(posedge clk or posedge rst)
    if (rst) q <= 1'b1;
    else q <= sig;
  assign fall = q & ~sig;
  assign rise = ~q & sig;
endmodule

// File: rtl/vga_timing_monitor.sv
// vga_timing_monitor: recovers position/lock/frame count from hsync/vsync and flags timing errors (in: clk rst hsync vsync err_clr; out: locked active pix_x pix_y frame_start frame_cnt h_err v_err)
module vga_timing_monitor
  import vga_timing_pkg::*;
#(
  parameter int HA = H_ACTIVE,
  parameter int HF = H_FP,
  parameter int HS = H_SYNC,
  parameter int HB = H_BP,
  parameter int VA = V_ACTIVE,
  parameter int VF = V_FP,
  parameter int VS = V_SYNC,
  parameter int VB = V_BP,
  parameter int LOCK_N = LOCK_FRAMES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        err_clr,
  output logic        locked,
  output logic        active,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic        frame_start,
  output logic [15:0] frame_cnt,
  output logic        h_err,
  output logic        v_err
);
  localparam logic [9:0] H_END = 10'(HA + HF + HS + HB - 1);
  localparam logic [9:0] H_SW = 10'(HS - 1);
  localparam logic [9:0] V_END = 10'(VA + VF + VS + VB - 1);
  localparam logic [9:0] V_SW = 10'(VS);
  localparam logic [9:0] HX0 = 10'(HS + HB);
  localparam logic [9:0] HX1 = 10'(HS + HB + HA - 1);
  localparam logic [9:0] VY0 = 10'(VS + VB);
  localparam logic [9:0] VY1 = 10'(VS + VB + VA - 1);
  localparam logic [9:0] SAT = 10'd1023;
  localparam logic [7:0] LOCK_G = 8'(LOCK_N);
  logic hfall, hrise, vfall, vrise, h_ev, v_ev, err_seen;
  logic [9:0] h_pos, v_pos, v_line;
  logic [7:0] good_frames, good_next;
  state_t state, state_next;
  sync_edge_detect u_hs (.clk(clk), .rst(rst), .sig(hsync), .fall(hfall), .rise(hrise));
  sync_edge_detect u_vs (.clk(clk), .rst(rst), .sig(vsync), .fall(vfall), .rise(vrise));
  assign v_line = hfall ? v_pos + 10'd1 : v_pos;
  assign h_ev = (hfall & state != SEARCH & h_pos != H_END) | (hrise & h_pos != H_SW) | (h_pos == SAT);
  assign v_ev = (vfall & state != SEARCH & v_pos != V_END) | (vrise & v_line != V_SW) | (v_pos == SAT);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      h_pos <= '0;
      v_pos <= '0;
    end else begin
      h_pos <= hfall ? '0 : h_pos == SAT ? SAT : h_pos + 10'd1;
      v_pos <= vfall ? '0 : (!hfall || v_pos == SAT) ? v_pos : v_pos + 10'd1;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= SEARCH;
      good_frames <= '0;
      err_seen <= 1'b0;
    end else begin
      state <= state_next;
      good_frames <= good_next;
      err_seen <= vfall ? 1'b0 : err_seen | h_ev | v_ev;
    end
  always_comb begin
    state_next = state;
    good_next = good_frames;
    if (state == SEARCH) begin
      if (vfall) begin
        state_next = ALIGN;
        good_next = '0;
      end
    end else if (h_ev | v_ev) begin
      state_next = ALIGN;
      good_next = '0;
    end else if (vfall && state == ALIGN && !err_seen) begin
      good_next = good_frames + 8'd1;
      if (good_next == LOCK_G) state_next = LOCKED;
    end
  end
  always_comb begin
    active = locked && h_pos >= HX0 && h_pos <= HX1 && v_pos >= VY0 && v_pos <= VY1;
    pix_x = active ? h_pos - HX0 : '0;
    pix_y = active ? v_pos - VY0 : '0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      locked <= 1'b0;
      frame_start <= 1'b0;
      frame_cnt <= '0;
      h_err <= 1'b0;
      v_err <= 1'b0;
    end else begin
      locked <= state_next == LOCKED;
      frame_start <= vfall;
      frame_cnt <= frame_cnt + 16'(vfall & state_next == LOCKED);
      h_err <= h_ev | (h_err & !err_clr);
      v_err <= v_ev | (v_err & !err_clr);
    end
endmodule
